// File: rtl/log_pixel_packer.sv
// log_pixel_packer
//   Packs 8-bit companded pixels from the logarithmic LUT stage into
//   BYTES_PER_WORD-byte words for the memory writer. The first pixel of a
//   word lands in the least significant byte. An end-of-frame pixel closes
//   the word early, and out_keep marks which bytes hold pixels.
//
// Ports
//   sys_clk    system clock, rising edge
//   sys_rst    asynchronous active-high reset
//   in_data    8-bit pixel
//   in_valid   in_data valid
//   in_last    last pixel of frame (qualified by in_valid)
//   in_ready   packer accepts a pixel this cycle
//   out_data   packed word (8*BYTES_PER_WORD bits)
//   out_keep   byte-valid mask, bit i = byte i
//   out_last   word closes a frame
//   out_valid  out_data/out_keep/out_last valid
//   out_ready  downstream accepts the word
module log_pixel_packer #(
  parameter int BYTES_PER_WORD = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]   out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [W-1:0]              acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [W-1:0]              out_data_q, out_data_d;
  logic [BYTES_PER_WORD-1:0] out_keep_q, out_keep_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;

  logic                      accept;
  logic                      complete;
  logic                      drain;
  logic [W-1:0]              merged;
  logic [BYTES_PER_WORD-1:0] keep_mask;

  always_comb begin
    // Ready only depends on the output register, so a stalled word can
    // never be overwritten and the source sees no combinational loop.
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    complete = accept && ((cnt_q == CW'(BYTES_PER_WORD - 1)) || in_last);
    drain    = out_valid_q && out_ready;

    // Accumulator with the incoming pixel dropped into byte cnt. Bytes above
    // cnt are forced to zero so a short (flushed) word is clean.
    merged    = '0;
    keep_mask = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (CW'(i) == cnt_q) begin
        merged[8*i +: 8] = in_data;
      end else if (CW'(i) < cnt_q) begin
        merged[8*i +: 8] = acc_q[8*i +: 8];
      end
      keep_mask[i] = (CW'(i) <= cnt_q);
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (complete) begin
      // A completing accept wins over a same-cycle drain: the new word
      // replaces the one being taken, keeping full throughput.
      out_data_d  = merged;
      out_keep_d  = keep_mask;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
      if (drain) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/log_pixel_packer.md
Name: log_pixel_packer

Overview:
- Sits directly downstream of the 12-to-8-bit logarithmic LUT stage.
- Collects 8-bit companded pixels into wide words for the memory writer/DMA.
- Valid/ready handshake on both sides; end-of-frame marker flushes any partial word with a byte-keep mask.
- Pixel order: first pixel in the least significant byte.

Parameters:
- BYTES_PER_WORD, 8, pixels per output word (power of two, 2..16); output width W = 8*BYTES_PER_WORD.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- in_data  in  8  companded pixel from the logarithmic stage.
- in_valid  in  1  in_data valid.
- in_last  in  1  pixel is the last of the frame; qualified by in_valid.
- in_ready  out  1  packer can accept a pixel this cycle.
- out_data  out  W  packed word.
- out_keep  out  BYTES_PER_WORD  byte-valid mask, bit i = byte i.
- out_last  out  1  word closes a frame.
- out_valid  out  1  out_data/out_keep/out_last valid.
- out_ready  in  1  downstream accepts the word.

Behaviour:
- Registered state:
  - accumulator acc[W-1:0].
  - byte counter cnt, range 0..BYTES_PER_WORD-1.
  - output register bank: out_data, out_keep, out_last, out_valid.
- Reset (asynchronous, immediate):
  - acc=0, cnt=0, out_data=0, out_keep=0, out_last=0, out_valid=0.
  - A partial word in progress is discarded; no word is emitted for it.
- in_ready = !out_valid || out_ready. This is purely combinational from output state and does not depend on in_valid or in_data.
- Accept: in_valid && in_ready. On accept, the pixel is written to byte cnt of the packed value.
- Completion condition on accept: cnt == BYTES_PER_WORD-1 OR in_last.
- Completing accept, same clock edge:
  - out_data <= acc with byte cnt replaced by in_data; bytes above cnt forced to 0.
  - out_keep <= mask with bits 0..cnt set.
  - out_last <= in_last.
  - out_valid <= 1.
  - cnt <= 0; acc <= 0.
- Non-completing accept: acc byte cnt <= in_data; cnt <= cnt+1.
- Latency: a word is visible on out_* one cycle after the accept of its final pixel.
- Output drain: when out_valid && out_ready and there is no completing accept in the same cycle, out_valid <= 0. out_data/out_keep/out_last may hold their stale values.
- Simultaneous drain and completing accept: the new word loads and out_valid stays 1. Sustained throughput is 1 pixel/cycle and one word per BYTES_PER_WORD cycles, with no bubble.
- Backpressure:
  - While out_valid && !out_ready, all out_* outputs stay stable and in_ready=0.
  - No pixel is accepted, so none can be lost or overwritten.
- Boundary cases:
  - in_last on the pixel that also fills the word: a single word with full keep and out_last=1; no extra empty word.
  - in_last with cnt==0: one-byte word, keep = 0x01.
  - in_valid with in_ready=0: inputs are ignored; the source must hold them.
  - in_last without in_valid: ignored.
- The block keeps no frame state; a new frame starts at byte 0 after any out_last word.

Test Plan:
- Full word, out_ready=1: pixels 0x01..0x08 on consecutive cycles -> one cycle after the 8th accept, out_valid=1, out_data=0x0807060504030201, out_keep=0xFF, out_last=0; out_valid high for exactly 1 cycle.
- Partial flush: 0xAA, 0xBB, 0xCC with in_last on 0xCC -> out_data=0x0000000000CCBBAA, out_keep=0x07, out_last=1.
- Backpressure: word pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, out_* unchanged. Raise out_ready -> word taken, the next 8 pixels form the next word with no loss or duplication.
- Reset mid-word: accept 5 pixels, pulse sys_rst asynchronously between edges, then send 0x10..0x17 -> out_valid drops immediately on reset; the first word after reset is 0x1716151413121110 with keep=0xFF.
- Aligned last: 8 pixels with in_last on the 8th -> exactly one word, out_keep=0xFF, out_last=1; no following word with keep=0.
- Streaming: 64 incrementing pixels with random in_valid gaps and random out_ready -> exactly 8 words in order, each with keep=0xFF, and no bubbles while in_valid=out_ready=1.
